// File: rtl/autocor_win_inc_pkg.sv
// Shared definitions for the windowed autocorrelation increment block:
// FSM state encodings and a constant-evaluable ceil(log2) helper.
package autocor_win_inc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        STOP  = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/autocor_win_inc_rise_det.sv
// Rising-edge detector on the sampled input: registers din every cycle
// and flags a 0->1 transition combinationally.
module autocor_win_inc_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;
    logic din_d;

    always_comb din_d = din;

    // NOTE: flops use non-blocking assignments so every register samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) din_q <= 1'b0;
        else     din_q <= din_d;
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/autocor_win_inc.sv
// Windowed rise counter feeding a saturated phase-increment word.
// Optional build macro AUTOCOR_AVG_EN averages each result with the previous one.
module autocor_win_inc
    import autocor_win_inc_pkg::*;
#(
    parameter int NR_W  = 4,
    parameter int INC_W = 8,
    parameter int WIN   = 64,
    parameter int STEP  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [NR_W-1:0]  nrise,
    output logic [INC_W-1:0] inc,
    output logic             inc_vld,
    output logic             busy
);

    localparam int WCNT_W = clog2(WIN);
    localparam int PROD_W = NR_W + clog2(STEP + 1);
    localparam int CMP_W  = (PROD_W > INC_W) ? PROD_W : INC_W;
    localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(WIN - 1);
    localparam logic [CMP_W-1:0]  INC_MAX  = CMP_W'({INC_W{1'b1}});

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [NR_W-1:0]    acc_q, acc_d;
    logic [NR_W-1:0]    nrise_q, nrise_d;
    logic [INC_W-1:0]   inc_q, inc_d;
    logic               inc_vld_q, inc_vld_d;

    logic               rise;
    logic               win_end;
    logic [NR_W-1:0]    fin;
    logic [PROD_W-1:0]  prod;
    logic [CMP_W-1:0]   prod_ext;
    logic [INC_W-1:0]   raw;
    logic [INC_W-1:0]   inc_new;

    autocor_win_inc_rise_det u_rise_det (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .rise (rise)
    );

    // The accumulator sticks at all-ones; a rise in the final cycle is included in fin.
    always_comb begin
        fin      = (&acc_q) ? acc_q : acc_q + NR_W'(rise);
        win_end  = (state_q != IDLE) && (wcnt_q == WIN_LAST);
        prod     = PROD_W'(fin) * PROD_W'(STEP);
        prod_ext = CMP_W'(prod);
        raw      = (prod_ext > INC_MAX) ? {INC_W{1'b1}} : prod_ext[INC_W-1:0];
    end

`ifdef AUTOCOR_AVG_EN
    logic [INC_W-1:0] prev_inc_q, prev_inc_d;
    logic [INC_W:0]   avg_sum;

    always_comb begin
        avg_sum    = {1'b0, raw} + {1'b0, prev_inc_q};
        inc_new    = avg_sum[INC_W:1];
        prev_inc_d = win_end ? raw : prev_inc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_inc_q <= '0;
        else     prev_inc_q <= prev_inc_d;
    end
`else
    always_comb inc_new = raw;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        acc_d     = acc_q;
        nrise_d   = nrise_q;
        inc_d     = inc_q;
        inc_vld_d = 1'b0;

        case (state_q)
            IDLE: begin
                wcnt_d = '0;
                acc_d  = '0;
                if (en) state_d = COUNT;
            end
            COUNT, STOP: begin
                wcnt_d  = wcnt_q + WCNT_W'(1);
                acc_d   = fin;
                state_d = en ? COUNT : STOP;
                if (win_end) begin
                    wcnt_d    = '0;
                    acc_d     = '0;
                    nrise_d   = fin;
                    inc_d     = inc_new;
                    inc_vld_d = 1'b1;
                    state_d   = (state_q == STOP) ? IDLE : COUNT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            acc_q     <= '0;
            nrise_q   <= '0;
            inc_q     <= '0;
            inc_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            acc_q     <= acc_d;
            nrise_q   <= nrise_d;
            inc_q     <= inc_d;
            inc_vld_q <= inc_vld_d;
        end
    end

    assign nrise   = nrise_q;
    assign inc     = inc_q;
    assign inc_vld = inc_vld_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_autocor_win_inc.sv
// Directed self-checking bench for autocor_win_inc (WIN=64, STEP=16, NR_W=4, INC_W=8).
// Expected increments follow AUTOCOR_AVG_EN when the bench is built with it.
module tb_autocor_win_inc;

    localparam int NR_W  = 4;
    localparam int INC_W = 8;
    localparam int WIN   = 64;
    localparam int STEP  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             din;
    logic [NR_W-1:0]  nrise;
    logic [INC_W-1:0] inc;
    logic             inc_vld;
    logic             busy;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [INC_W-1:0] prev_model;

    autocor_win_inc #(
        .NR_W  (NR_W),
        .INC_W (INC_W),
        .WIN   (WIN),
        .STEP  (STEP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .din     (din),
        .nrise   (nrise),
        .inc     (inc),
        .inc_vld (inc_vld),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // din pattern by window cycle index
    function automatic logic pat(input int mode, input int i);
        case (mode)
            0:       return 1'b0;             // all low
            1:       return 1'b1;             // held high
            2:       return (i % 8) >= 4;     // period 8: 8 rises per window
            3:       return (i % 2) == 1;     // period 2: 32 rises per window
            4:       return i == 63;          // single rise in the last cycle
            5:       return (i % 16) >= 8;    // period 16: 4 rises per window
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input logic d);
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic model_inc(input logic [INC_W-1:0] raw, output logic [INC_W-1:0] exp_inc);
`ifdef AUTOCOR_AVG_EN
        logic [INC_W:0] s;
        s          = {1'b0, raw} + {1'b0, prev_model};
        prev_model = raw;
        exp_inc    = s[INC_W:1];
`else
        exp_inc = raw;
`endif
    endtask

    // Runs one full 64-cycle window with en held high.
    task automatic run_window(input string tag, input int mode, input int exp_nrise, input int exp_raw);
        logic [INC_W-1:0] exp_inc;
        int vld_seen;
        int busy_low;
        vld_seen = 0;
        busy_low = 0;
        for (int i = 0; i < WIN; i++) begin
            step(pat(mode, i));
            if (i < WIN - 1) begin
                if (inc_vld) vld_seen++;
                if (!busy)   busy_low++;
            end
        end
        model_inc(INC_W'(exp_raw), exp_inc);
        check({tag, ".early_vld"}, vld_seen, 0);
        check({tag, ".busy_gap"},  busy_low, 0);
        check({tag, ".vld"},       inc_vld,  1);
        check({tag, ".busy"},      busy,     1);
        check({tag, ".nrise"},     nrise,    exp_nrise);
        check({tag, ".inc"},       inc,      exp_inc);
    endtask

    initial begin
        logic [INC_W-1:0] exp_inc;
        int vld_seen;
        int busy_seen;

        rst        = 1'b1;
        en         = 1'b0;
        din        = 1'b0;
        prev_model = '0;

        // Reset held with din toggling
        #1;
        for (int i = 0; i < 3; i++) begin
            step(i[0]);
            check("rst.nrise",   nrise,   0);
            check("rst.inc",     inc,     0);
            check("rst.inc_vld", inc_vld, 0);
            check("rst.busy",    busy,    0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(i[0]);
            check("idle.busy",    busy,    0);
            check("idle.inc_vld", inc_vld, 0);
        end

        // Back-to-back windows, period-8 input
        en = 1'b1;
        step(1'b0);
        check("start.busy", busy, 1);
        run_window("sq8a", 2, 8, 128);
        run_window("sq8b", 2, 8, 128);

        // Saturation, then din held high across the window boundary
        run_window("tog2",  3, 15, 240);
        run_window("hold1", 1, 0,  0);

        // Single rise in the last window cycle, then an empty window
        run_window("last63",  4, 1, 16);
        run_window("after63", 0, 0, 0);

        // en toggled inside a window and finally dropped: window runs to the end
        vld_seen  = 0;
        busy_seen = 0;
        for (int i = 0; i < WIN; i++) begin
            en = (i < 10) ? 1'b1 : (i < 20) ? 1'b0 : (i < 30) ? 1'b1 : 1'b0;
            step(pat(2, i));
            if (i < WIN - 1) begin
                if (inc_vld) vld_seen++;
                if (!busy)   busy_seen++;
            end
        end
        model_inc(8'd128, exp_inc);
        check("stop.early_vld", vld_seen, 0);
        check("stop.busy_gap",  busy_seen, 0);
        check("stop.vld",       inc_vld,  1);
        check("stop.busy",      busy,     0);
        check("stop.nrise",     nrise,    8);
        check("stop.inc",       inc,      exp_inc);
        vld_seen  = 0;
        busy_seen = 0;
        for (int i = 0; i < 70; i++) begin
            step(pat(3, i));
            if (inc_vld) vld_seen++;
            if (busy)    busy_seen++;
        end
        check("stop.no_more_vld", vld_seen,  0);
        check("stop.stay_idle",   busy_seen, 0);
        check("stop.hold_nrise",  nrise,     8);
        check("stop.hold_inc",    inc,       exp_inc);

        // Async reset in window cycle 30
        en = 1'b1;
        step(1'b0);
        for (int i = 0; i < 30; i++) step(pat(2, i));
        check("midrst.pre_busy",  busy,  1);
        check("midrst.pre_nrise", nrise, 8);
        #2;
        rst = 1'b1;
        #1;
        prev_model = '0;
        check("midrst.nrise",   nrise,   0);
        check("midrst.inc",     inc,     0);
        check("midrst.inc_vld", inc_vld, 0);
        check("midrst.busy",    busy,    0);
        en = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        vld_seen  = 0;
        busy_seen = 0;
        for (int i = 0; i < 70; i++) begin
            step(pat(2, i));
            if (inc_vld) vld_seen++;
            if (busy)    busy_seen++;
        end
        check("midrst.no_vld",   vld_seen,  0);
        check("midrst.no_busy",  busy_seen, 0);
        check("midrst.nrise_0",  nrise,     0);

        // 8 then 4 rises after reset (averaged when AUTOCOR_AVG_EN is set)
        en = 1'b1;
        step(1'b0);
        run_window("avg8", 2, 8, 128);
        run_window("avg4", 5, 4, 64);

        en = 1'b0;
        step(1'b0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/autocor_win_inc.md
Name: autocor_win_inc

Overview:
- Windowed, sequential successor to the combinational autocorrelation increment mapper in the NN-PLL analog-Verilog model.
- Counts rising edges of the 1-bit sampled input `din` over a fixed window of WIN clocks, then converts the count to a saturated phase-increment word `inc`.
- Windows run back-to-back with no gap while enabled; each result is flagged by a one-cycle valid pulse.
- Feeds the PLL increment/NCO path, replacing a hand-supplied nrise.

Parameters:
- NR_W, 4, width of the rise counter and of the nrise output.
- INC_W, 8, width of the increment output.
- WIN, 64, window length in clock cycles; legal range is WIN >= 2.
- STEP, 16, increment weight per counted rise.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable.
- din  in  1  sampled input bitstream.
- nrise  out  NR_W  rise count of the last completed window.
- inc  out  INC_W  increment derived from the last completed window.
- inc_vld  out  1  one-cycle pulse when nrise and inc update.
- busy  out  1  high while a window is in progress.

Behaviour:
- Reset values: nrise=0, inc=0, inc_vld=0, busy=0, state=IDLE, internal counters=0, din_q=0.
- rst is asynchronous and active-high, and may assert at any time.
- Edge detect:
  - din_q <= din every cycle, in every state.
  - rise = din & ~din_q.
- Window counter: wcnt, width $clog2(WIN).
- Rise accumulator: acc, NR_W bits, saturating at 2^NR_W-1 and never wrapping.
- State IDLE:
  - busy=0; wcnt and acc hold 0.
  - en=1 → COUNT. The next cycle is window cycle 0.
- State COUNT:
  - busy=1.
  - Each cycle: wcnt++ and acc += rise, saturating.
  - en=0 → STOP. The current window still completes.
- State STOP:
  - Counting continues exactly as in COUNT.
  - en=1 → COUNT. The window is not restarted.
- Window end (wcnt==WIN-1, in COUNT or STOP):
  - Final count fin = sat(acc + rise); a rise in the last cycle is counted.
  - Next edge: nrise <= fin; inc <= min(fin*STEP, 2^INC_W-1); inc_vld <= 1; wcnt <= 0.
  - acc <= 0, so there is no gap between windows.
  - If the end-cycle state is COUNT: stay in COUNT.
  - If the end-cycle state is STOP: go to IDLE, and busy drops on that same edge.
- Multiply width: the product is NR_W+$clog2(STEP+1) bits, then saturated to INC_W.
- Latency: inc_vld is high in the cycle after the window's last cycle, for exactly one cycle.
- Hold: nrise and inc hold their values between updates.
- Reset mid-window: the partial window is discarded, no inc_vld is produced, and outputs return to 0 immediately.
- en toggled 1→0→1 inside a single window: window timing is unaffected.

Optional Feature:
- Macro: AUTOCOR_AVG_EN.
- When defined:
  - A prev_inc register is added, reset to 0.
  - At window end: raw = min(fin*STEP, max); inc <= (raw + prev_inc) >> 1; prev_inc <= raw.
  - The addition uses INC_W+1 bits.
  - The first window after reset averages against 0.
  - nrise is unaffected by the averaging.
- When undefined: inc = raw, and no prev_inc register exists.

Decomposition:
- Shared include alg_defs.vh holds:
  - the FSM state encodings (IDLE=2'd0, COUNT=2'd1, STOP=2'd2) as localparams;
  - a clog2 function.
- One natural sub-module: rise_det, containing the din_q register and the rise output.

Test Plan (WIN=64, STEP=16, NR_W=4, INC_W=8, macro undefined unless noted):
1. Assert rst for 3 cycles with din toggling → all outputs 0 and busy=0 throughout; release rst with en=0 → busy stays 0.
2. en=1 held, din square wave of period 8 → inc_vld every 64 cycles, nrise=8, inc=128; busy stays 1 with no gap between windows.
3. en=1, din period-2 toggle (32 rises per window) → nrise=15 (saturated), inc=240; din held at 1 from before the window → nrise=0, inc=0.
4. en=1, a single din rise in window cycle 63 → nrise=1, inc=16, counted in that window; the next window reports 0.
5. en dropped at window cycle 10 → window runs to cycle 63, one inc_vld, busy=0 on the next cycle, no further pulses; async rst at window cycle 30 → immediate zeros, no inc_vld.
6. AUTOCOR_AVG_EN defined, successive windows with 8 then 4 rises → inc=64 then 96.
